pipe_mode_ctrl: RTL and testbench

Parametrised pipeline mode controller that sequences the core through instruction load, normal run, branch flush and memory-wait modes. It drives the global pipeline hold and flush-hold signals consumed by every pipeline stage register. Unlike the previous single-source controller, it accepts multiple memory-wait sources and has a configurable flush length. It also keeps a branch that arrives during a memory wait instead of dropping it, and enters a sticky fault mode on a stalled-memory timeout.

---
 rtl/pipe_mode_ctrl_if.sv | 38 +++
 rtl/pipe_mode_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_mode_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mode_ctrl_if.sv
// Handshake bundle between the pipeline mode controller and the core:
// load/branch/memory-wait requests in, hold/flush controls and status out.
interface pipe_mode_ctrl_if #(
    parameter int unsigned NUM_WAIT = 2
);
    localparam int unsigned CAUSE_W = (NUM_WAIT > 1) ? $clog2(NUM_WAIT) : 1;

    logic                instrWriteDone;
    logic                branchJump;
    logic [NUM_WAIT-1:0] memWait;
    logic                MASTER_HOLD;
    logic                FLUSH_HOLD;
    logic [2:0]          mode;
    logic                fault;
    logic [CAUSE_W-1:0]  waitCause;

    modport master (
        output instrWriteDone,
        output branchJump,
        output memWait,
        input  MASTER_HOLD,
        input  FLUSH_HOLD,
        input  mode,
        input  fault,
        input  waitCause
    );

    modport slave (
        input  instrWriteDone,
        input  branchJump,
        input  memWait,
        output MASTER_HOLD,
        output FLUSH_HOLD,
        output mode,
        output fault,
        output waitCause
    );
endinterface

// File: rtl/pipe_mode_ctrl.sv
// Pipeline mode controller: sequences LOAD/RUN/FLUSH/MEMWAIT/FAULT and drives the
// global hold and flush-hold signals. Moore outputs decoded from registered state.
module pipe_mode_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned NUM_WAIT     = 2,
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input logic             clk,
    input logic             rst,
    pipe_mode_ctrl_if.slave bus
);
    localparam int unsigned CAUSE_W = (NUM_WAIT > 1) ? $clog2(NUM_WAIT) : 1;
    localparam int unsigned FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned WC_W    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    localparam logic [2:0] ST_LOAD    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_FLUSH   = 3'd2;
    localparam logic [2:0] ST_MEMWAIT = 3'd3;
    localparam logic [2:0] ST_FAULT   = 3'd4;

    logic [2:0]         r_state, w_state;
    logic [FC_W-1:0]    r_flush_ctr, w_flush_ctr;
    logic [WC_W-1:0]    r_wait_ctr, w_wait_ctr;
    logic               r_branch_pending, w_branch_pending;
    logic [CAUSE_W-1:0] r_wait_cause, w_wait_cause;
    logic [CAUSE_W-1:0] w_lowest;
    logic               w_any_wait;
    logic               w_timeout;

    assign w_any_wait = |bus.memWait;
    assign w_timeout  = (WAIT_TIMEOUT != 0) && (r_wait_ctr == WC_W'(WAIT_TIMEOUT - 1));

    // Scan downwards so the lowest set index wins.
    always_comb begin
        w_lowest = '0;
        for (int i = NUM_WAIT - 1; i >= 0; i--) begin
            if (bus.memWait[i]) w_lowest = CAUSE_W'(i);
        end
    end

    always_comb begin
        w_state          = r_state;
        w_flush_ctr      = r_flush_ctr;
        w_wait_ctr       = r_wait_ctr;
        w_branch_pending = r_branch_pending;
        w_wait_cause     = r_wait_cause;
        case (r_state)
            ST_LOAD: begin
                if (bus.instrWriteDone) w_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_any_wait) begin
                    w_state          = ST_MEMWAIT;
                    w_wait_ctr       = '0;
                    w_wait_cause     = w_lowest;
                    w_branch_pending = bus.branchJump;
                end else if (bus.branchJump) begin
                    w_state     = ST_FLUSH;
                    w_flush_ctr = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_MEMWAIT: begin
                w_branch_pending = r_branch_pending | bus.branchJump;
                if (w_any_wait && w_timeout) begin
                    w_state = ST_FAULT;
                end else if (w_any_wait) begin
                    if (r_wait_ctr != '1) w_wait_ctr = r_wait_ctr + 1'b1;
                end else if (r_branch_pending || bus.branchJump) begin
                    w_state          = ST_FLUSH;
                    w_flush_ctr      = FC_W'(FLUSH_CYCLES - 1);
                    w_branch_pending = 1'b0;
                end else begin
                    w_state = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (r_flush_ctr == '0) w_state = ST_RUN;
                else w_flush_ctr = r_flush_ctr - 1'b1;
            end
            default: ;  // FAULT is terminal until reset
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_LOAD;
            r_flush_ctr      <= '0;
            r_wait_ctr       <= '0;
            r_branch_pending <= 1'b0;
            r_wait_cause     <= '0;
        end else begin
            r_state          <= w_state;
            r_flush_ctr      <= w_flush_ctr;
            r_wait_ctr       <= w_wait_ctr;
            r_branch_pending <= w_branch_pending;
            r_wait_cause     <= w_wait_cause;
        end
    end

    assign bus.MASTER_HOLD = (r_state == ST_LOAD) || (r_state == ST_MEMWAIT) ||
                             (r_state == ST_FAULT);
    assign bus.FLUSH_HOLD  = (r_state == ST_FLUSH);
    assign bus.fault       = (r_state == ST_FAULT);
    assign bus.mode        = r_state;
    assign bus.waitCause   = r_wait_cause;
endmodule

// File: tb/tb_pipe_mode_ctrl.sv
// Bench for pipe_mode_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a cycle-count model.
module tb_pipe_mode_ctrl;
    localparam int unsigned FC = 4;
    localparam int unsigned NW = 2;
    localparam int unsigned TO = 8;

    localparam int M_LOAD = 0, M_RUN = 1, M_FLUSH = 2, M_WAIT = 3, M_FAULT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_mode_ctrl_if #(.NUM_WAIT(NW)) bus ();

    pipe_mode_ctrl #(
        .FLUSH_CYCLES(FC),
        .NUM_WAIT    (NW),
        .WAIT_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: mode name plus "cycles left in flush" and "cycles spent waiting".
    int m_mode;
    int m_flush_left;
    int m_wait_len;
    int m_cause;
    bit m_pending;
    bit m_valid = 1'b0;

    function automatic int lowest_set(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_LOAD; m_flush_left = 0; m_wait_len = 0;
            m_cause = 0; m_pending = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            case (m_mode)
                M_LOAD: if (bus.instrWriteDone) m_mode = M_RUN;
                M_RUN: begin
                    if (bus.memWait != 0) begin
                        m_mode = M_WAIT; m_wait_len = 1;
                        m_cause = lowest_set(bus.memWait); m_pending = bus.branchJump;
                    end else if (bus.branchJump) begin
                        m_mode = M_FLUSH; m_flush_left = FC;
                    end
                end
                M_WAIT: begin
                    if (bus.memWait != 0) begin
                        m_pending = m_pending | bus.branchJump;
                        if (TO != 0 && m_wait_len == TO) m_mode = M_FAULT;
                        else m_wait_len++;
                    end else if (m_pending || bus.branchJump) begin
                        m_mode = M_FLUSH; m_flush_left = FC; m_pending = 1'b0;
                    end else begin
                        m_mode = M_RUN;
                    end
                end
                M_FLUSH: begin
                    if (m_flush_left == 1) m_mode = M_RUN;
                    else m_flush_left--;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("mode", int'(bus.mode), m_mode);
            check("MASTER_HOLD", int'(bus.MASTER_HOLD),
                  int'(m_mode == M_LOAD || m_mode == M_WAIT || m_mode == M_FAULT));
            check("FLUSH_HOLD", int'(bus.FLUSH_HOLD), int'(m_mode == M_FLUSH));
            check("fault", int'(bus.fault), int'(m_mode == M_FAULT));
            check("waitCause", int'(bus.waitCause), m_cause);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instrWriteDone = 1'b0;
        bus.branchJump     = 1'b0;
        bus.memWait        = '0;
    endtask

    int burst;

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;

        // Reset state and load
        check("rst_mode", int'(bus.mode), M_LOAD);
        check("rst_mh", int'(bus.MASTER_HOLD), 1);
        check("rst_fh", int'(bus.FLUSH_HOLD), 0);
        check("rst_cause", int'(bus.waitCause), 0);
        bus.branchJump = 1'b1; bus.memWait = 2'b11;
        repeat (3) tick();
        check("load_ignores", int'(bus.mode), M_LOAD);
        idle_inputs();
        bus.instrWriteDone = 1'b1;
        tick();
        bus.instrWriteDone = 1'b0;
        check("load_run", int'(bus.mode), M_RUN);
        check("load_mh", int'(bus.MASTER_HOLD), 0);

        // Branch flush, with extra pulses during flush ignored
        bus.branchJump = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("br_fh", int'(bus.FLUSH_HOLD), 1);
            check("br_mode", int'(bus.mode), M_FLUSH);
            bus.branchJump = 1'b1;
            tick();
        end
        bus.branchJump = 1'b0;
        check("br_end", int'(bus.mode), M_RUN);
        check("br_end_fh", int'(bus.FLUSH_HOLD), 0);

        // Simultaneous wait (source 1) and branch: wait first, then flush
        bus.memWait = 2'b10; bus.branchJump = 1'b1;
        tick();
        bus.branchJump = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wb_mode", int'(bus.mode), M_WAIT);
            check("wb_cause", int'(bus.waitCause), 1);
            if (i == 2) bus.memWait = '0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("wb_flush", int'(bus.mode), M_FLUSH);
            tick();
        end
        check("wb_run", int'(bus.mode), M_RUN);

        // Hand-off between sources: one continuous wait
        for (int i = 0; i < 6; i++) begin
            bus.memWait = (i < 3) ? 2'b01 : 2'b10;
            tick();
            check("ho_mode", int'(bus.mode), M_WAIT);
            check("ho_cause", int'(bus.waitCause), 0);
        end
        bus.memWait = '0;
        tick();
        check("ho_run", int'(bus.mode), M_RUN);
        check("ho_mh", int'(bus.MASTER_HOLD), 0);
        check("ho_cause_kept", int'(bus.waitCause), 0);

        // Timeout into sticky fault
        bus.memWait = 2'b11;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("to_wait", int'(bus.mode), M_WAIT);
            tick();
        end
        check("to_fault_mode", int'(bus.mode), M_FAULT);
        check("to_fault", int'(bus.fault), 1);
        check("to_mh", int'(bus.MASTER_HOLD), 1);
        bus.memWait = '0; bus.branchJump = 1'b1; bus.instrWriteDone = 1'b1;
        repeat (3) tick();
        check("to_sticky", int'(bus.mode), M_FAULT);
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to_rst_mode", int'(bus.mode), M_LOAD);
        check("to_rst_fault", int'(bus.fault), 0);

        // Reset mid-flush
        bus.instrWriteDone = 1'b1;
        tick();
        bus.instrWriteDone = 1'b0;
        bus.branchJump = 1'b1;
        tick();
        bus.branchJump = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mf_mode", int'(bus.mode), M_LOAD);
        check("mf_fh", int'(bus.FLUSH_HOLD), 0);
        check("mf_mh", int'(bus.MASTER_HOLD), 1);

        // Randomized traffic
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            rst                = ($urandom_range(0, 149) == 0);
            bus.instrWriteDone = ($urandom_range(0, 3) == 0);
            bus.branchJump     = ($urandom_range(0, 5) == 0);
            if (burst > 0) begin
                burst--;
                bus.memWait = NW'($urandom_range(1, 3));
            end else if ($urandom_range(0, 7) == 0) begin
                burst = $urandom_range(0, 11);
                bus.memWait = NW'($urandom_range(1, 3));
            end else begin
                bus.memWait = '0;
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
